uat_tx_sched: RTL and testbench

- Two-requester packet scheduler for the shared uat serial transmitter in the printer-emulator datapath.
- Requester 0 is the printer image dump and requester 1 is the status/debug message stream.
- Round-robin arbitration happens only at packet boundaries, so bytes from the two streams never interleave.
- Drives the transmitter's toggle-style tx_cmd/tx_din and paces bytes from its tx_ready.

---
 rtl/uat_tx_sched_pkg.sv | 17 +
 rtl/uat_rr_arb2.sv | 16 +
 rtl/uat_tx_sched.sv | 151 +++++++++++++++
 tb/tb_uat_tx_sched.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uat_tx_sched_pkg.sv
// uat_tx_sched_pkg: shared types for the uat transmit scheduler.
// Holds the scheduler state encoding and the byte width.
package uat_tx_sched_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        ISSUE     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4,
        GAP       = 3'd5,
        DRAIN     = 3'd6
    } sched_state_t;

endpackage

// File: rtl/uat_rr_arb2.sv
// uat_rr_arb2: combinational 2-way round-robin pick.
// Ports: req0/req1 requests, last_grant previous owner,
//        gnt_valid any request, gnt_id chosen requester.
module uat_rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_id
);

    assign gnt_valid = req0 | req1;
    // A lone requester wins outright; a tie goes to the one not served last.
    assign gnt_id = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/uat_tx_sched.sv
// uat_tx_sched: packet-atomic two-requester scheduler for the uat transmitter.
// Ports: clk, srst (sync, active high); s0_*/s1_* valid/ready byte streams
//   with last; tx_din/tx_cmd (toggle) to the transmitter, tx_ready from it;
//   busy, grant (current/last owner), wdog_err (sticky).
// Optional: define UAT_TX_SCHED_WDOG_EN to add the tx_ready watchdog.
import uat_tx_sched_pkg::*;

module uat_tx_sched #(
    parameter int GAP_CYCLES  = 0,
    parameter int WDOG_CYCLES = 32
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              s0_valid,
    input  logic [BYTE_W-1:0] s0_data,
    input  logic              s0_last,
    output logic              s0_ready,
    input  logic              s1_valid,
    input  logic [BYTE_W-1:0] s1_data,
    input  logic              s1_last,
    output logic              s1_ready,
    output logic [BYTE_W-1:0] tx_din,
    output logic              tx_cmd,
    input  logic              tx_ready,
    output logic              busy,
    output logic              grant,
    output logic              wdog_err
);

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    sched_state_t      state;
    logic              last_r;
    logic [7:0]        gap_cnt;
    logic              gnt_valid;
    logic              gnt_id;
    logic              sel_valid;
    logic [BYTE_W-1:0] sel_data;
    logic              sel_last;
    logic              take;

`ifdef UAT_TX_SCHED_WDOG_EN
    localparam int WDW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(WDOG_CYCLES - 1);
    logic [WDW-1:0] wd_cnt;
`else
    assign wdog_err = 1'b0;
`endif

    uat_rr_arb2 u_arb (
        .req0       (s0_valid),
        .req1       (s1_valid),
        .last_grant (grant),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    assign sel_valid = grant ? s1_valid : s0_valid;
    assign sel_data  = grant ? s1_data  : s0_data;
    assign sel_last  = grant ? s1_last  : s0_last;

    // Only the owner is ever offered ready; DRAIN swallows a dead packet.
    assign take     = (state == FETCH) || (state == DRAIN);
    assign s0_ready = take && !grant;
    assign s1_ready = take && grant;

    always_ff @(posedge clk) begin
        if (srst) begin
            state   <= IDLE;
            tx_cmd  <= 1'b0;
            tx_din  <= '0;
            busy    <= 1'b0;
            grant   <= 1'b1;
            last_r  <= 1'b0;
            gap_cnt <= '0;
`ifdef UAT_TX_SCHED_WDOG_EN
            wd_cnt   <= '0;
            wdog_err <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        grant <= gnt_id;
                        busy  <= 1'b1;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (sel_valid) begin
                        tx_din <= sel_data;
                        last_r <= sel_last;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    tx_cmd <= ~tx_cmd;
`ifdef UAT_TX_SCHED_WDOG_EN
                    wd_cnt <= '0;
`endif
                    state  <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!tx_ready) begin
                        state <= WAIT_DONE;
                    end
`ifdef UAT_TX_SCHED_WDOG_EN
                    else if (wd_cnt == WD_LAST) begin
                        wdog_err <= 1'b1;
                        if (last_r) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (wd_cnt != '1) begin
                        wd_cnt <= wd_cnt + WDW'(1);
                    end
`endif
                end
                WAIT_DONE: begin
                    if (tx_ready) begin
                        if (GAP_CYCLES > 0) begin
                            gap_cnt <= '0;
                            state   <= GAP;
                        end else begin
                            busy  <= !last_r;
                            state <= last_r ? IDLE : FETCH;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        busy  <= !last_r;
                        state <= last_r ? IDLE : FETCH;
                    end else if (gap_cnt != 8'hFF) begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                DRAIN: begin
                    if (sel_valid && sel_last) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uat_tx_sched.sv
// tb_uat_tx_sched: randomized bench for uat_tx_sched with a transmitter
// model and a packet-level round-robin reference model.
module tb_uat_tx_sched;

    localparam int GAP  = 10;
    localparam int WDOG = 32;

    logic       clk = 1'b0;
    logic       srst = 1'b1;
    logic       s0_valid, s0_last, s0_ready;
    logic       s1_valid, s1_last, s1_ready;
    logic [7:0] s0_data, s1_data, tx_din;
    logic       tx_cmd, tx_ready, busy, grant, wdog_err;

    uat_tx_sched #(.GAP_CYCLES(GAP), .WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .srst(srst),
        .s0_valid(s0_valid), .s0_data(s0_data),
        .s0_last(s0_last), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_data(s1_data),
        .s1_last(s1_last), .s1_ready(s1_ready),
        .tx_din(tx_din), .tx_cmd(tx_cmd), .tx_ready(tx_ready),
        .busy(busy), .grant(grant), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct { logic [7:0] d; logic l; } beat_t;
    typedef struct { logic [7:0] d; logic o; logic first; } exp_t;

    beat_t q0[$], q1[$];
    beat_t st0[$], st1[$];
    exp_t  eq[$];
    logic  mdl_owner = 1'b1;

    int  rise_cyc = -1;
    int  tog_cyc  = 0;
    int  n_tog    = 0;
    int  nbytes   = 0;
    int  bad_rdy  = 0;
    bit  dead     = 0;

    task automatic add_beat(input int who, input logic [7:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        if (who == 0) begin q0.push_back(b); st0.push_back(b); end
        else          begin q1.push_back(b); st1.push_back(b); end
    endtask

    task automatic add_pkt(input int who, input int len);
        for (int i = 0; i < len; i++)
            add_beat(who, 8'($urandom), i == len - 1);
    endtask

    // Whole packets in round-robin order, decided only between packets.
    task automatic build_exp();
        beat_t b;
        exp_t  e;
        bit    first;
        while (st0.size() > 0 || st1.size() > 0) begin
            if (st0.size() > 0 && st1.size() > 0) mdl_owner = ~mdl_owner;
            else mdl_owner = (st0.size() > 0) ? 1'b0 : 1'b1;
            first = 1;
            do begin
                b = mdl_owner ? st1.pop_front() : st0.pop_front();
                e.d = b.d; e.o = mdl_owner; e.first = first;
                eq.push_back(e);
                first = 0;
            end while (!b.l);
        end
    endtask

    // Requesters: present queue heads, pop after an accepted transfer.
    initial begin
        bit pend0 = 0, pend1 = 0;
        s0_valid = 0; s0_data = 0; s0_last = 0;
        s1_valid = 0; s1_data = 0; s1_last = 0;
        forever begin
            @(negedge clk);
            if (srst) begin
                q0.delete(); q1.delete();
                pend0 = 0; pend1 = 0;
                s0_valid = 0; s1_valid = 0;
                continue;
            end
            if ((s0_ready && s1_ready) || (s0_ready && grant) ||
                (s1_ready && !grant)) bad_rdy++;
            if (pend0) void'(q0.pop_front());
            if (pend1) void'(q1.pop_front());
            s0_valid = q0.size() > 0;
            s0_data  = s0_valid ? q0[0].d : 8'h00;
            s0_last  = s0_valid ? q0[0].l : 1'b0;
            s1_valid = q1.size() > 0;
            s1_data  = s1_valid ? q1[0].d : 8'h00;
            s1_last  = s1_valid ? q1[0].l : 1'b0;
            pend0 = s0_valid && s0_ready;
            pend1 = s1_valid && s1_ready;
        end
    end

    // Transmitter: toggle -> sync delay -> busy frame -> idle.
    initial begin
        int         phase = 0, cnt = 0;
        logic       last_cmd = 1'b0;
        logic [7:0] cap = 8'h00;
        bit         stable = 1;
        exp_t       e;
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (srst) begin
                phase = 0; tx_ready = 1'b1;
                last_cmd = 1'b0; rise_cyc = -1;
                continue;
            end
            case (phase)
                0: if (tx_cmd !== last_cmd) begin
                    last_cmd = tx_cmd;
                    n_tog++;
                    tog_cyc = cyc;
                    if (!dead) begin
                        if (eq.size() > 0 && rise_cyc >= 0)
                            chk("gap", cyc - rise_cyc, GAP + (eq[0].first ? 4 : 3));
                        cnt = $urandom_range(3, 5);
                        phase = 1;
                    end
                end
                1: begin
                    cnt--;
                    if (cnt == 0) begin
                        tx_ready = 1'b0;
                        cap = tx_din;
                        stable = 1;
                        nbytes++;
                        if (eq.size() == 0) chk("extra_byte", 1, 0);
                        else begin
                            e = eq.pop_front();
                            chk("data", cap, e.d);
                            chk("owner", grant, e.o);
                        end
                        cnt = $urandom_range(12, 40);
                        phase = 2;
                    end
                end
                default: begin
                    if (tx_din !== cap) stable = 0;
                    cnt--;
                    if (cnt == 0) begin
                        tx_ready = 1'b1;
                        rise_cyc = cyc;
                        chk("din_stable", stable, 1);
                        phase = 0;
                    end
                end
            endcase
        end
    end

    task automatic wait_done(input string tag);
        int k = 0;
        while ((eq.size() > 0 || busy || !tx_ready ||
                q0.size() > 0 || q1.size() > 0) && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, k < 20000, 1);
        repeat (3) @(negedge clk);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int t0, k;
        repeat (3) @(negedge clk);
        chk("rst_cmd", tx_cmd, 0);
        chk("rst_din", tx_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 1);
        chk("rst_wdog", wdog_err, 0);
        chk("rst_rdy", {s0_ready, s1_ready}, 0);
        srst = 1'b0;
        @(negedge clk);

        add_beat(0, 8'h01, 0); add_beat(0, 8'h02, 0); add_beat(0, 8'h03, 1);
        add_beat(1, 8'hFF, 1);
        build_exp();
        rise_cyc = -1;
        wait_done("atomic");
        chk("atomic_tog", n_tog, 4);

        t0 = n_tog;
        add_beat(0, 8'hA5, 1);
        build_exp();
        rise_cyc = -1;
        wait_done("single");
        chk("single_tog", n_tog - t0, 1);
        chk("single_din", tx_din, 8'hA5);

        for (int r = 0; r < 3; r++) begin
            for (int p = $urandom_range(2, 5); p > 0; p--) add_pkt(0, $urandom_range(1, 4));
            for (int p = $urandom_range(2, 5); p > 0; p--) add_pkt(1, $urandom_range(1, 4));
            build_exp();
            rise_cyc = -1;
            wait_done("rand");
        end
        chk("ready_excl", bad_rdy, 0);

        t0 = nbytes;
        for (int i = 0; i < 4; i++) add_beat(0, 8'(8'h40 + i), i == 3);
        build_exp();
        rise_cyc = -1;
        k = 0;
        while (nbytes < t0 + 2 && k < 5000) begin @(negedge clk); k++; end
        chk("mid_reach", k < 5000, 1);
        repeat (2) @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        chk("mid_cmd", tx_cmd, 0);
        chk("mid_busy", busy, 0);
        chk("mid_rdy", {s0_ready, s1_ready}, 0);
        @(negedge clk);
        srst = 1'b0;
        eq.delete();
        mdl_owner = 1'b1;
        t0 = n_tog;
        repeat (100) @(negedge clk);
        chk("mid_notog", n_tog, t0);
        chk("mid_idle", busy, 0);

`ifdef UAT_TX_SCHED_WDOG_EN
        dead = 1;
        t0 = n_tog;
        for (int i = 0; i < 3; i++) add_beat(0, 8'(8'h70 + i), i == 2);
        st0.delete();
        k = 0;
        while (!wdog_err && k < 500) begin @(negedge clk); k++; end
        chk("wdog_set", wdog_err, 1);
        chk("wdog_lat", cyc - tog_cyc, WDOG);
        k = 0;
        while ((busy || q0.size() > 0) && k < 500) begin @(negedge clk); k++; end
        repeat (3) @(negedge clk);
        chk("wdog_drain", q0.size(), 0);
        chk("wdog_idle", busy, 0);
        chk("wdog_tog", n_tog - t0, 1);
        chk("wdog_sticky", wdog_err, 1);
        dead = 0;
`else
        chk("wdog_off", wdog_err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
